// File: rtl/retire_trace_buffer_if.sv
// retire_trace_buffer_if: retire-group input bus and trace drain handshake for the retire trace buffer
interface retire_trace_buffer_if #(parameter int NUM_CH = 1);
  logic [NUM_CH-1:0]      ret_valid;
  logic [32*NUM_CH-1:0]   ret_pc;
  logic [32*NUM_CH-1:0]   ret_instr;
  logic [NUM_CH-1:0]      ret_wr_en;
  logic [5*NUM_CH-1:0]    ret_wr_reg;
  logic [32*NUM_CH-1:0]   ret_wr_data;
  logic [32*NUM_CH-1:0]   ret_v0;
  logic                   trc_valid;
  logic                   trc_ready;
  logic [31:0]            trc_seq;
  logic [31:0]            trc_pc;
  logic [31:0]            trc_instr;
  logic [31:0]            trc_wr_data;
  logic                   trc_wr_en;
  logic [4:0]             trc_wr_reg;
  modport master (
    output ret_valid, ret_pc, ret_instr, ret_wr_en, ret_wr_reg, ret_wr_data, ret_v0, trc_ready,
    input  trc_valid, trc_seq, trc_pc, trc_instr, trc_wr_data, trc_wr_en, trc_wr_reg
  );
  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_wr_en, ret_wr_reg, ret_wr_data, ret_v0, trc_ready,
    output trc_valid, trc_seq, trc_pc, trc_instr, trc_wr_data, trc_wr_en, trc_wr_reg
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: multi-lane retire capture FIFO with sequence tags, end-of-test detect and counters.
// Optional watchdog enabled by defining TRACE_TIMEOUT_EN.
module retire_trace_buffer #(
  parameter int NUM_CH         = 1,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  retire_trace_buffer_if.slave  bus,
  output logic                  stall_req,
  output logic                  overflow,
  output logic                  done,
  output logic [31:0]           cycle_count,
  output logic [31:0]           retire_count,
  output logic                  timeout
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [4:0]  wr_reg;
  } entry_t;
  entry_t      mem_q [DEPTH];
  entry_t      mem_d [DEPTH];
  entry_t      head;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, free, n;
  logic [31:0] seq_q, seq_d, cyc_q, cyc_d, ret_q, ret_d, add;
  logic        ovf_q, ovf_d, done_q, done_d, stop, pop;
  // Lanes are compacted in order; a terminal lane stops the scan so younger lanes vanish silently.
  always_comb begin
    free   = (AW+1)'(DEPTH) - (wr_q - rd_q);
    mem_d  = mem_q;
    n      = '0;
    add    = '0;
    stop   = done_q;
    ovf_d  = ovf_q;
    done_d = done_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ret_valid[i] && !stop) begin
        add = add + 32'd1;
        if (n < free) begin
          mem_d[wr_q[AW-1:0] + n[AW-1:0]] = '{seq: seq_q + 32'(n), pc: bus.ret_pc[32*i +: 32],
            instr: bus.ret_instr[32*i +: 32], wr_data: bus.ret_wr_data[32*i +: 32],
            wr_en: bus.ret_wr_en[i], wr_reg: bus.ret_wr_reg[5*i +: 5]};
          n = n + (AW+1)'(1);
          if (bus.ret_instr[32*i +: 32] == 32'h0000000C && bus.ret_v0[32*i +: 32] == 32'h0000000A) begin
            stop   = 1'b1;
            done_d = 1'b1;
          end
        end else ovf_d = 1'b1;
      end
    end
  end
  always_comb begin
    pop   = bus.trc_valid && bus.trc_ready;
    wr_d  = wr_q + n;
    rd_d  = rd_q + (AW+1)'(pop);
    seq_d = seq_q + 32'(n);
    ret_d = ret_q + add;
    cyc_d = done_q ? cyc_q : cyc_q + 32'd1;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      seq_q  <= '0;
      cyc_q  <= '0;
      ret_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      seq_q  <= seq_d;
      cyc_q  <= cyc_d;
      ret_q  <= ret_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end
`ifdef TRACE_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        to_q, to_d;
  always_comb begin
    wd_d = done_q ? wd_q : (|bus.ret_valid) ? '0 : to_q ? wd_q : wd_q + 32'd1;
    to_d = to_q || (wd_d >= 32'(TIMEOUT_CYCLES));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
  assign timeout = to_q;
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  assign head            = mem_q[rd_q[AW-1:0]];
  assign bus.trc_valid   = wr_q != rd_q;
  assign bus.trc_seq     = bus.trc_valid ? head.seq     : '0;
  assign bus.trc_pc      = bus.trc_valid ? head.pc      : '0;
  assign bus.trc_instr   = bus.trc_valid ? head.instr   : '0;
  assign bus.trc_wr_data = bus.trc_valid ? head.wr_data : '0;
  assign bus.trc_wr_en   = bus.trc_valid ? head.wr_en   : 1'b0;
  assign bus.trc_wr_reg  = bus.trc_valid ? head.wr_reg  : '0;
  assign stall_req       = (free < (AW+1)'(NUM_CH)) || done_q || timeout;
  assign overflow        = ovf_q;
  assign done            = done_q;
  assign cycle_count     = cyc_q;
  assign retire_count    = ret_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: scoreboard bench for retire_trace_buffer (NUM_CH=2, DEPTH=4).
module tb_retire_trace_buffer;
  localparam int NC = 2, DP = 4, TO = 8;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  retire_trace_buffer_if #(.NUM_CH(NC)) bus();
  logic        stall_req, overflow, done, timeout;
  logic [31:0] cycle_count, retire_count;
  retire_trace_buffer #(.NUM_CH(NC), .DEPTH(DP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall_req(stall_req), .overflow(overflow), .done(done),
    .cycle_count(cycle_count), .retire_count(retire_count), .timeout(timeout)
  );
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [4:0]  wr_reg;
  } ent_t;
  ent_t        sb[$];
  int          checks = 0, errors = 0;
  int          mocc, mwd;
  logic [31:0] mseq, mcyc, mcnt;
  logic        mdone, movf, mto;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    ent_t e;
    if (!reset) begin
      chk("trc_valid", 32'(bus.trc_valid), 32'(sb.size() != 0));
      if (!bus.trc_valid)
        chk("idle_zero", bus.trc_pc | bus.trc_seq | bus.trc_instr | bus.trc_wr_data | 32'({bus.trc_wr_en, bus.trc_wr_reg}), 32'd0);
      else if (bus.trc_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("trc_seq", bus.trc_seq, e.seq);
        chk("trc_pc", bus.trc_pc, e.pc);
        chk("trc_instr", bus.trc_instr, e.instr);
        chk("trc_wr_data", bus.trc_wr_data, e.wr_data);
        chk("trc_wr", 32'({bus.trc_wr_en, bus.trc_wr_reg}), 32'({e.wr_en, e.wr_reg}));
      end
    end
  end
  task automatic step(input logic [1:0] v, input logic [31:0] pc0, pc1, in0, in1, v00, v01, input logic rdy);
    ent_t        add_e[$];
    logic [31:0] pcs[2], ins[2], v0s[2];
    int          free, n, add;
    logic        stop, term, ovfn;
    pcs = '{pc0, pc1};
    ins = '{in0, in1};
    v0s = '{v00, v01};
    bus.ret_valid   = v;
    bus.ret_pc      = {pc1, pc0};
    bus.ret_instr   = {in1, in0};
    bus.ret_v0      = {v01, v00};
    bus.ret_wr_en   = {pc1[2], pc0[2]};
    bus.ret_wr_reg  = {pc1[6:2], pc0[6:2]};
    bus.ret_wr_data = {~pc1, ~pc0};
    bus.trc_ready   = rdy;
    free = DP - mocc;
    stop = mdone;
    n = 0; add = 0; term = 1'b0; ovfn = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (v[i] && !stop) begin
        add++;
        if (n < free) begin
          add_e.push_back('{mseq + 32'(n), pcs[i], ins[i], ~pcs[i], pcs[i][2], pcs[i][6:2]});
          n++;
          if (ins[i] == 32'hC && v0s[i] == 32'hA) begin
            stop = 1'b1;
            term = 1'b1;
          end
        end else ovfn = 1'b1;
      end
    end
    #2 chk("stall_req", 32'(stall_req), 32'((free < NC) || mdone || mto));
    @(posedge clk);
    foreach (add_e[k]) sb.push_back(add_e[k]);
    if (rdy && mocc > 0) mocc--;
    mocc += n;
    mseq += 32'(n);
    mcnt += 32'(add);
    if (!mdone) mcyc++;
`ifdef TRACE_TIMEOUT_EN
    if (!mdone) begin
      if (v != 0) mwd = 0;
      else if (!mto) mwd++;
      if (mwd >= TO) mto = 1'b1;
    end
`endif
    mdone |= term;
    movf  |= ovfn;
    #1;
  endtask
  task automatic st(input logic [1:0] v, input logic [31:0] pc0, pc1, input logic rdy);
    step(v, pc0, pc1, {pc0[15:0], 16'h1234}, {pc1[15:0], 16'h5678}, 32'hA, 32'hA, rdy);
  endtask
  task automatic idle(input int k, input logic rdy);
    repeat (k) st(2'b00, 32'h0, 32'h0, rdy);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.ret_valid = '0;
    bus.trc_ready = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    mocc = 0; mwd = 0; mseq = 0; mcyc = 0; mcnt = 0;
    mdone = 1'b0; movf = 1'b0; mto = 1'b0;
    chk("rst_valid", 32'(bus.trc_valid), 32'd0);
    chk("rst_flags", 32'({overflow, done, timeout, stall_req}), 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    reset = 1'b0;
  endtask
  initial begin
    bus.ret_valid = '0; bus.ret_pc = '0; bus.ret_instr = '0; bus.ret_v0 = '0;
    bus.ret_wr_en = '0; bus.ret_wr_reg = '0; bus.ret_wr_data = '0; bus.trc_ready = 1'b0;
    do_reset;
    st(2'b01, 32'h0, 32'h0, 1'b1);
    st(2'b01, 32'h4, 32'h0, 1'b1);
    st(2'b01, 32'h8, 32'h0, 1'b1);
    idle(2, 1'b1);
    chk("retire_count_3", retire_count, 32'd3);
    chk("cycle_count_5", cycle_count, 32'd5);
    st(2'b10, 32'h0, 32'h100, 1'b1);
    st(2'b11, 32'h200, 32'h204, 1'b1);
    step(2'b01, 32'h300, 32'h0, 32'hC, 32'h0, 32'h5, 32'h0, 1'b1);
    idle(3, 1'b1);
    chk("retire_count_7", retire_count, 32'd7);
    chk("not_done", 32'(done), 32'd0);
    chk("cycle_count_run", cycle_count, mcyc);
    do_reset;
    st(2'b11, 32'h10, 32'h14, 1'b0);
    st(2'b11, 32'h18, 32'h1c, 1'b0);
    chk("ovf_before", 32'(overflow), 32'd0);
    st(2'b11, 32'h20, 32'h24, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("retire_ovf", retire_count, 32'd6);
    idle(1, 1'b0);
    idle(5, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_reset;
    st(2'b11, 32'h40, 32'h44, 1'b0);
    st(2'b11, 32'h48, 32'h4c, 1'b0);
    st(2'b11, 32'h60, 32'h64, 1'b1);
    chk("ovf_full_pop", 32'(overflow), 32'd1);
    idle(5, 1'b1);
    do_reset;
    step(2'b11, 32'h80, 32'h84, 32'hC, 32'h1234, 32'hA, 32'hA, 1'b1);
    chk("done_set", 32'(done), 32'd1);
    chk("done_no_ovf", 32'(overflow), 32'd0);
    chk("done_retire", retire_count, 32'd1);
    st(2'b11, 32'h90, 32'h94, 1'b1);
    st(2'b01, 32'h98, 32'h0, 1'b1);
    chk("cycle_frozen", cycle_count, 32'd1);
    chk("retire_frozen", retire_count, 32'd1);
    chk("done_sticky", 32'(done), 32'd1);
`ifdef TRACE_TIMEOUT_EN
    do_reset;
    idle(7, 1'b0);
    chk("timeout_early", 32'(timeout), 32'd0);
    idle(1, 1'b0);
    chk("timeout_set", 32'(timeout), 32'd1);
    chk("timeout_stall", 32'(stall_req), 32'd1);
    do_reset;
`else
    do_reset;
    idle(10, 1'b0);
    chk("timeout_off", 32'(timeout), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
